// File: rtl/micro_pkg.sv
// Shared types and constants for the instruction sequencer and its opcode decoder.
package micro_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_M,
        S_FETCH_I,
        S_DECODE,
        S_START,
        S_WAIT,
        S_HALT,
        S_FAULT
    } state_e;

    // The ALU owns every opcode from OP_ALU_LO up to 4'b1111.
    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_MOV    = 4'b0001;
    localparam logic [3:0] OP_LDI    = 4'b0010;
    localparam logic [3:0] OP_HALT   = 4'b1000;
    localparam logic [3:0] OP_ALU_LO = 4'b1001;

    localparam logic [1:0] U_MOV = 2'd0;
    localparam logic [1:0] U_LDI = 2'd1;
    localparam logic [1:0] U_ALU = 2'd2;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;
    localparam logic [1:0] FC_UNEXP   = 2'b11;

    function automatic logic [2:0] unit_onehot(input logic [1:0] sel);
        return 3'b001 << sel;
    endfunction

endpackage

// File: rtl/opcode_decode.sv
// Maps a 4-bit opcode to its class and executor select; shared with the debug monitor.
module opcode_decode
    import micro_pkg::*;
(
    input  logic [3:0] opc,
    output logic       is_nop,
    output logic       is_halt,
    output logic       legal,
    output logic [1:0] sel
);

    always_comb begin
        is_nop  = 1'b0;
        is_halt = 1'b0;
        legal   = 1'b0;
        sel     = U_MOV;
        if (opc == OP_NOP) begin
            is_nop = 1'b1;
            legal  = 1'b1;
        end else if (opc == OP_HALT) begin
            is_halt = 1'b1;
            legal   = 1'b1;
        end else if (opc == OP_MOV) begin
            sel   = U_MOV;
            legal = 1'b1;
        end else if (opc == OP_LDI) begin
            sel   = U_LDI;
            legal = 1'b1;
        end else if (opc >= OP_ALU_LO) begin
            sel   = U_ALU;
            legal = 1'b1;
        end
    end

endmodule

// File: rtl/instr_dispatch.sv
// Instruction sequencer: fetches into IR, hands the bus to one executor FSM, and retires.
//
// state     | meaning
// IDLE      | waiting for run
// FETCH_A   | PC onto bus, latch MAR
// FETCH_M   | memory read until mem_ready
// FETCH_I   | MDR onto bus, capture IR
// DECODE    | classify opcode; NOP/HALT retire here
// START     | one-cycle start pulse to the selected executor
// WAIT      | executor owns the bus until done or timeout
// HALT      | parked until a fresh rising edge on run
// FAULT     | sticky error, cleared only by reset
module instr_dispatch
    import micro_pkg::*;
#(
    parameter int TIMEOUT_CYC = 32,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [15:0] bus_in,
    input  logic [2:0]  unit_done,
    output logic        pc_out,
    output logic        mar_in,
    output logic        mem_rd,
    output logic        mdr_out,
    output logic        pc_inc,
    output logic [15:0] ir,
    output logic [2:0]  unit_start,
    output logic [2:0]  unit_grant,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [15:0] retired
);

    state_e          state, state_n;
    logic [1:0]      sel_q;
    logic            nop_q, halt_q, legal_q;
    logic            dec_nop, dec_halt, dec_legal;
    logic [1:0]      dec_sel;
    logic [TO_W-1:0] to_cnt;
    logic            run_q;
    logic            retire;
    logic [1:0]      code_n;
    logic [2:0]      sel_mask, allowed;

    // Decode the word on the bus during FETCH_I so DECODE-cycle outputs can be registered.
    opcode_decode u_dec (
        .opc     (bus_in[15:12]),
        .is_nop  (dec_nop),
        .is_halt (dec_halt),
        .legal   (dec_legal),
        .sel     (dec_sel)
    );

    always_comb begin
        sel_mask = unit_onehot(sel_q);
        allowed  = (state == S_START || state == S_WAIT) ? sel_mask : 3'b000;
        state_n  = state;
        code_n   = FC_NONE;
        retire   = 1'b0;
        // A done from an executor that does not own the bus beats any legal done.
        if (state != S_FAULT && (unit_done & ~allowed) != 3'b000) begin
            state_n = S_FAULT;
            code_n  = FC_UNEXP;
        end else begin
            case (state)
                S_IDLE:    if (run) state_n = S_FETCH_A;
                S_FETCH_A: state_n = S_FETCH_M;
                S_FETCH_M: if (mem_ready) state_n = S_FETCH_I;
                S_FETCH_I: state_n = S_DECODE;
                S_DECODE: begin
                    if (!legal_q) begin
                        state_n = S_FAULT;
                        code_n  = FC_ILLEGAL;
                    end else if (nop_q) begin
                        retire  = 1'b1;
                        state_n = run ? S_FETCH_A : S_IDLE;
                    end else if (halt_q) begin
                        retire  = 1'b1;
                        state_n = S_HALT;
                    end else begin
                        state_n = S_START;
                    end
                end
                S_START:   state_n = S_WAIT;
                S_WAIT: begin
                    if ((unit_done & sel_mask) != 3'b000) begin
                        retire  = 1'b1;
                        state_n = run ? S_FETCH_A : S_IDLE;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        state_n = S_FAULT;
                        code_n  = FC_TIMEOUT;
                    end
                end
                S_HALT:    if (run && !run_q) state_n = S_FETCH_A;
                S_FAULT:   state_n = S_FAULT;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            ir         <= '0;
            sel_q      <= U_MOV;
            nop_q      <= 1'b0;
            halt_q     <= 1'b0;
            legal_q    <= 1'b0;
            to_cnt     <= '0;
            run_q      <= 1'b0;
            retired    <= '0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            pc_out     <= 1'b0;
            mar_in     <= 1'b0;
            mem_rd     <= 1'b0;
            mdr_out    <= 1'b0;
            pc_inc     <= 1'b0;
            unit_start <= 3'b000;
            unit_grant <= 3'b000;
            halted     <= 1'b0;
        end else begin
            state   <= state_n;
            run_q   <= run;
            retired <= retired + 16'(retire);
            if (state == S_FETCH_I && state_n == S_DECODE) begin
                ir      <= bus_in;
                sel_q   <= dec_sel;
                nop_q   <= dec_nop;
                halt_q  <= dec_halt;
                legal_q <= dec_legal;
            end
            // Counter reads 0 during START, so WAIT cycle k sees k.
            if (state_n == S_START)
                to_cnt <= '0;
            else if (state == S_START || state == S_WAIT)
                to_cnt <= to_cnt + TO_W'(1);
            if (state_n == S_FAULT && state != S_FAULT) begin
                fault      <= 1'b1;
                fault_code <= code_n;
            end
            pc_out     <= (state_n == S_FETCH_A);
            mar_in     <= (state_n == S_FETCH_A);
            mem_rd     <= (state_n == S_FETCH_M);
            mdr_out    <= (state_n == S_FETCH_I);
            pc_inc     <= (state_n == S_DECODE) && dec_nop;
            unit_start <= (state_n == S_START) ? sel_mask : 3'b000;
            unit_grant <= (state_n == S_START || state_n == S_WAIT) ? sel_mask : 3'b000;
            halted     <= (state_n == S_HALT);
        end
    end

endmodule

// File: doc/instr_dispatch.md
Name: instr_dispatch

Overview:
Top-level instruction sequencer for the microcontroller datapath.
- Fetches each 16-bit instruction over the shared bus and holds it in its own IR.
- Decodes the opcode and grants the bus to exactly one execution FSM: move, load-immediate or the ALU sequencer.
- Waits for that FSM's done pulse, then fetches the next instruction.
- Owns NOP, HALT, illegal-opcode and executor-timeout handling.

Parameters:
TIMEOUT_CYC, 32, max cycles in WAIT before FAULT (legal 2..255)
TO_W, 8, width of timeout counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset; synchronous, active-low; sampled on the rising edge of clk
run  in  1  level; leaves HALT/IDLE and begins fetching while high
mem_ready  in  1  memory read data valid on bus_in
bus_in  in  16  shared data bus (instruction word during FETCH_I)
unit_done  in  3  done pulses: [0] move, [1] load, [2] ALU
pc_out  out  1  drive PC onto bus
mar_in  out  1  latch bus into MAR
mem_rd  out  1  memory read strobe
mdr_out  out  1  drive MDR onto bus
pc_inc  out  1  PC increment (NOP only; executors increment for their own instructions)
ir  out  16  held instruction word, feeds all executors' fullBitNum
unit_start  out  3  one-cycle start pulse, one-hot
unit_grant  out  3  bus ownership, one-hot, held START..WAIT
halted  out  1  high in HALT
fault  out  1  sticky until reset
fault_code  out  2  01 illegal opcode, 10 timeout, 11 unexpected done
retired  out  16  count of completed instructions, wraps at 0xFFFF->0

Behaviour:
- States: IDLE, FETCH_A, FETCH_M, FETCH_I, DECODE, START, WAIT, HALT, FAULT.
- Registered Moore outputs: decoded from current state plus the held unit select.
- Reset (rst=0 at an edge), from any state including mid-WAIT:
  - state=IDLE, ir=0, retired=0, fault=0, fault_code=00.
  - All strobes, grants and starts drop to 0 the next cycle.
- IDLE: outputs 0. run=1 -> FETCH_A.
- FETCH_A: pc_out=1, mar_in=1 for 1 cycle -> FETCH_M.
- FETCH_M: mem_rd=1 held until mem_ready=1 (no timeout). Then -> FETCH_I.
- FETCH_I: mdr_out=1; ir<=bus_in at the end of this cycle -> DECODE.
- DECODE (1 cycle), by ir[15:12]:
  - 0000 NOP: pc_inc=1 this cycle, retired++, -> FETCH_A (or IDLE if run=0).
  - 1000 HALT: retired++, -> HALT.
  - 0001 -> sel=0; 0010 -> sel=1; 1001..1111 -> sel=2. Then -> START.
  - Any other opcode -> FAULT, fault_code=01.
- START: unit_start[sel]=1 and unit_grant[sel]=1 for 1 cycle. Timeout counter cleared to 0 -> WAIT.
- WAIT: unit_grant[sel]=1, counter increments each cycle.
  - unit_done[sel]=1 -> retired++, -> FETCH_A if run=1, else IDLE. Grant drops the cycle after done.
  - Counter reaches TIMEOUT_CYC-1 with no done -> FAULT, code 10.
  - unit_done on any non-selected bit (in any state) -> FAULT, code 11. This takes priority over a simultaneous legal done.
- ir is stable from the end of FETCH_I until the next FETCH_I. Executors rely on this; the ALU FSM needs the opcode held throughout.
- HALT: halted=1. Exit when run falls and later rises (edge-detected) -> FETCH_A. A held-high run does not re-trigger.
- FAULT: all strobes and grants 0, fault=1; stays until reset. run is ignored.
- Invariants: at most one of pc_out/mdr_out high per cycle; unit_grant is zero or one-hot; unit_start is a subset of unit_grant.

Decomposition:
- Package micro_pkg holds:
  - state enum
  - opcode constants: OP_NOP=0000, OP_MOV=0001, OP_LDI=0010, OP_HALT=1000, ALU range 1001..1111
  - unit index constants: U_MOV=0, U_LDI=1, U_ALU=2
  - fault code constants
- One sub-module, opcode_decode: combinational map from ir[15:12] to {is_nop, is_halt, legal, sel[1:0]}. It will be reused by the debug monitor.

Test Plan:
- Reset mid-WAIT with grant=100 → next cycle grant=000, state IDLE, retired=0, ir=0.
- ALU instruction 0x9042, mem_ready 2 cycles late, run=1 → unit_start=100 exactly 1 cycle; unit_done[2] pulsed after 9 cycles → retired=1, next cycle pc_out=1, mar_in=1.
- Stream NOP, 0x1000 (MOV), HALT with unit_done[0] after 3 cycles → pc_inc=1 once, retired=3, halted=1; run toggled 0->1 → FETCH_A.
- Opcode 0x5123 → fault=1, fault_code=01, no unit_start, strobes stay 0 thereafter.
- TIMEOUT_CYC=8, LDI with no done → fault_code=10 exactly 8 cycles after START, grant=000.
- ALU selected, unit_done=001 injected → fault_code=11; retired=0xFFFF then one NOP → retired=0x0000.
